// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : pong_pkg                                               |
// | Description : Shared constants for the pong datapath: coordinate     |
// |               widths, playfield/paddle/ball geometry, FSM encoding   |
// |               and a centring helper.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pong_pkg;

    // Coordinates leave the block 10 bits wide; internal arithmetic is
    // carried one bit wider so sums such as x+BALL_SIZE+STEP never wrap.
    localparam int c_coord_w = 10;
    localparam int c_arith_w = 11;

    localparam int c_screen_w    = 640;
    localparam int c_screen_h    = 480;
    localparam int c_ball_size   = 8;
    localparam int c_paddle_w    = 8;
    localparam int c_paddle_h    = 64;
    localparam int c_paddle_xl   = 16;
    localparam int c_paddle_xr   = 616;
    localparam int c_step        = 4;
    localparam int c_serve_delay = 32;
    localparam int c_win_score   = 9;

    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_serve = 2'd1;
    localparam logic [1:0] c_st_play  = 2'd2;
    localparam logic [1:0] c_st_over  = 2'd3;

    // Top-left coordinate that centres an object of 'size' in 'extent'.
    function automatic logic [c_coord_w-1:0] centre_coord(input int extent, input int size);
        return c_coord_w'((extent - size) / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tick_sync_edge                                         |
// | Description : Two-flop synchronizer followed by a registered rising- |
// |               edge detector. A rise on async_in yields a single      |
// |               one-clk pulse, asserted 3 clk after the rise.          |
// | Ports       : clk      - system clock                                |
// |               btnC     - asynchronous active-high reset              |
// |               async_in - level from another clock domain             |
// |               pulse    - one-clk pulse per rising edge of async_in   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tick_sync_edge (
    input  logic clk,
    input  logic btnC,
    input  logic async_in,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Registered so consumers see a clean, glitch-free pulse.
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/ball_motion_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ball_motion_engine                                     |
// | Description : Pong ball mover. Turns the divider's slow game clock   |
// |               into one-clk ticks; on each tick moves the ball,       |
// |               bounces it off walls and paddles, detects misses and   |
// |               keeps score under an IDLE/SERVE/PLAY/OVER FSM.         |
// | Ports       : clk, btnC (async reset), game_tick (async level),      |
// |               start, paddle_l_y/paddle_r_y (paddle tops) ->          |
// |               ball_x/ball_y, score_l/score_r, point_l/point_r        |
// |               pulses, game_over, state.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ball_motion_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = c_screen_w,
    parameter int SCREEN_H    = c_screen_h,
    parameter int BALL_SIZE   = c_ball_size,
    parameter int PADDLE_W    = c_paddle_w,
    parameter int PADDLE_H    = c_paddle_h,
    parameter int PADDLE_XL   = c_paddle_xl,
    parameter int PADDLE_XR   = c_paddle_xr,
    parameter int STEP        = c_step,
    parameter int SERVE_DELAY = c_serve_delay,
    parameter int WIN_SCORE   = c_win_score
) (
    input  logic                 clk,
    input  logic                 btnC,
    input  logic                 game_tick,
    input  logic                 start,
    input  logic [c_coord_w-1:0] paddle_l_y,
    input  logic [c_coord_w-1:0] paddle_r_y,
    output logic [c_coord_w-1:0] ball_x,
    output logic [c_coord_w-1:0] ball_y,
    output logic [3:0]           score_l,
    output logic [3:0]           score_r,
    output logic                 point_l,
    output logic                 point_r,
    output logic                 game_over,
    output logic [c_state_w-1:0] state
);

    localparam int c_cnt_w = $clog2(SERVE_DELAY + 1);

    // Wide-arithmetic geometry constants.
    localparam logic [c_arith_w-1:0] c_step_a    = c_arith_w'(STEP);
    localparam logic [c_arith_w-1:0] c_ball_a    = c_arith_w'(BALL_SIZE);
    localparam logic [c_arith_w-1:0] c_pad_h_a   = c_arith_w'(PADDLE_H);
    localparam logic [c_arith_w-1:0] c_xr_a      = c_arith_w'(PADDLE_XR);
    localparam logic [c_arith_w-1:0] c_xl_edge_a = c_arith_w'(PADDLE_XL + PADDLE_W);
    localparam logic [c_arith_w-1:0] c_scr_w_a   = c_arith_w'(SCREEN_W);
    localparam logic [c_arith_w-1:0] c_y_max_a   = c_arith_w'(SCREEN_H - BALL_SIZE);

    // Output-width constants.
    localparam logic [c_coord_w-1:0] c_y_max    = c_coord_w'(SCREEN_H - BALL_SIZE);
    localparam logic [c_coord_w-1:0] c_step_c   = c_coord_w'(STEP);
    localparam logic [c_coord_w-1:0] c_x_stop_r = c_coord_w'(PADDLE_XR - BALL_SIZE);
    localparam logic [c_coord_w-1:0] c_x_stop_l = c_coord_w'(PADDLE_XL + PADDLE_W);
    localparam logic [c_coord_w-1:0] c_centre_x = centre_coord(SCREEN_W, BALL_SIZE);
    localparam logic [c_coord_w-1:0] c_centre_y = centre_coord(SCREEN_H, BALL_SIZE);
    localparam logic [c_cnt_w-1:0]   c_serve    = c_cnt_w'(SERVE_DELAY);
    localparam logic [3:0]           c_win      = 4'(WIN_SCORE);

    logic [c_state_w-1:0] r_state;
    logic [c_coord_w-1:0] r_ball_x;
    logic [c_coord_w-1:0] r_ball_y;
    logic                 r_dx_right;
    logic                 r_dy_down;
    logic [3:0]           r_score_l;
    logic [3:0]           r_score_r;
    logic                 r_point_l;
    logic                 r_point_r;
    logic [c_cnt_w-1:0]   r_serve_cnt;

    logic                 w_tick;
    logic [c_arith_w-1:0] w_x;
    logic [c_arith_w-1:0] w_y;
    logic [c_arith_w-1:0] w_pl;
    logic [c_arith_w-1:0] w_pr;
    logic                 w_ov_l;
    logic                 w_ov_r;
    logic                 w_hit_l;
    logic                 w_hit_r;
    logic                 w_miss_l;
    logic                 w_miss_r;
    logic [c_coord_w-1:0] w_next_y;
    logic                 w_next_dy;
    logic [3:0]           w_score_l_inc;
    logic [3:0]           w_score_r_inc;

    tick_sync_edge u_tick (
        .clk      (clk),
        .btnC     (btnC),
        .async_in (game_tick),
        .pulse    (w_tick)
    );

    assign w_x  = {1'b0, r_ball_x};
    assign w_y  = {1'b0, r_ball_y};
    assign w_pl = {1'b0, paddle_l_y};
    assign w_pr = {1'b0, paddle_r_y};

    // Paddle overlap uses the pre-move ball_y so the X decision matches
    // what was on screen when the tick arrived.
    assign w_ov_l = (w_y + c_ball_a > w_pl) && (w_y < w_pl + c_pad_h_a);
    assign w_ov_r = (w_y + c_ball_a > w_pr) && (w_y < w_pr + c_pad_h_a);

    // A hit needs the ball to be in front of the paddle face now and to
    // cross it on this step; a ball already past the face can only miss.
    assign w_hit_r  = r_dx_right && (w_x + c_ball_a <= c_xr_a)
                      && (w_x + c_ball_a + c_step_a > c_xr_a) && w_ov_r;
    assign w_hit_l  = !r_dx_right && (w_x >= c_xl_edge_a)
                      && (w_x < c_xl_edge_a + c_step_a) && w_ov_l;
    assign w_miss_r = r_dx_right && (w_x + c_ball_a + c_step_a > c_scr_w_a);
    assign w_miss_l = !r_dx_right && (w_x < c_step_a);

    assign w_score_l_inc = r_score_l + 4'd1;
    assign w_score_r_inc = r_score_r + 4'd1;

    // Vertical step with wall clamp and bounce.
    always_comb begin
        w_next_y  = r_ball_y;
        w_next_dy = r_dy_down;
        if (r_dy_down) begin
            if (w_y + c_step_a >= c_y_max_a) begin
                w_next_y  = c_y_max;
                w_next_dy = 1'b0;
            end else begin
                w_next_y  = r_ball_y + c_step_c;
            end
        end else begin
            if (w_y < c_step_a) begin
                w_next_y  = '0;
                w_next_dy = 1'b1;
            end else begin
                w_next_y  = r_ball_y - c_step_c;
            end
        end
    end

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            r_state     <= c_st_idle;
            r_ball_x    <= c_centre_x;
            r_ball_y    <= c_centre_y;
            r_dx_right  <= 1'b1;
            r_dy_down   <= 1'b1;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_point_l   <= 1'b0;
            r_point_r   <= 1'b0;
            r_serve_cnt <= '0;
        end else begin
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_serve;
                        r_serve_cnt <= c_serve;
                    end
                end
                c_st_serve: begin
                    if (w_tick) begin
                        if (r_serve_cnt == c_cnt_w'(1)) begin
                            r_state <= c_st_play;
                        end
                        r_serve_cnt <= r_serve_cnt - c_cnt_w'(1);
                    end
                end
                c_st_play: begin
                    if (w_tick) begin
                        r_ball_y  <= w_next_y;
                        r_dy_down <= w_next_dy;
                        if (w_hit_r) begin
                            r_ball_x   <= c_x_stop_r;
                            r_dx_right <= 1'b0;
                        end else if (w_hit_l) begin
                            r_ball_x   <= c_x_stop_l;
                            r_dx_right <= 1'b1;
                        end else if (w_miss_r) begin
                            // Left player scores; re-serve toward the right.
                            r_score_l  <= w_score_l_inc;
                            r_point_l  <= 1'b1;
                            r_ball_x   <= c_centre_x;
                            r_ball_y   <= c_centre_y;
                            r_dx_right <= 1'b1;
                            if (w_score_l_inc == c_win) begin
                                r_state <= c_st_over;
                            end else begin
                                r_state     <= c_st_serve;
                                r_serve_cnt <= c_serve;
                            end
                        end else if (w_miss_l) begin
                            r_score_r  <= w_score_r_inc;
                            r_point_r  <= 1'b1;
                            r_ball_x   <= c_centre_x;
                            r_ball_y   <= c_centre_y;
                            r_dx_right <= 1'b0;
                            if (w_score_r_inc == c_win) begin
                                r_state <= c_st_over;
                            end else begin
                                r_state     <= c_st_serve;
                                r_serve_cnt <= c_serve;
                            end
                        end else if (r_dx_right) begin
                            r_ball_x <= r_ball_x + c_step_c;
                        end else begin
                            r_ball_x <= r_ball_x - c_step_c;
                        end
                    end
                end
                default: begin
                    // Over: ball stays at centre until a restart.
                    if (start) begin
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_state     <= c_st_serve;
                        r_serve_cnt <= c_serve;
                    end
                end
            endcase
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign point_l   = r_point_l;
    assign point_r   = r_point_r;
    assign state     = r_state;
    assign game_over = (r_state == c_st_over);

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ball_motion_engine                                  |
// | Description : Self-checking bench for ball_motion_engine. A          |
// |               behavioural model of the game rules is compared with   |
// |               the DUT every clock; literal expectations pin the      |
// |               model at the interesting points of a rally.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ball_motion_engine;

    logic       clk = 1'b0;
    logic       btnC;
    logic       game_tick;
    logic       start;
    logic [9:0] paddle_l_y;
    logic [9:0] paddle_r_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       point_l;
    logic       point_r;
    logic       game_over;
    logic [1:0] state;

    ball_motion_engine dut (
        .clk        (clk),
        .btnC       (btnC),
        .game_tick  (game_tick),
        .start      (start),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .point_l    (point_l),
        .point_r    (point_r),
        .game_over  (game_over),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model of the game: 0 idle, 1 serve, 2 play, 3 over.
    int m_state, m_cnt, m_bx, m_by, m_dxr, m_dyd, m_sl, m_sr, m_pl, m_pr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_bx = 316; m_by = 236;
        m_dxr = 1; m_dyd = 1; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0;
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 3) begin
            if (m_state == 3) begin
                m_sl = 0; m_sr = 0;
            end
            m_state = 1; m_cnt = 32;
        end
    endtask

    // One game tick by the rules: Y first, then X with the old Y.
    task automatic model_tick();
        int oy, ny, pl, pr;
        bit ovl, ovr;
        if (m_state == 1) begin
            m_cnt--;
            if (m_cnt == 0) m_state = 2;
        end else if (m_state == 2) begin
            oy = m_by;
            pl = int'(paddle_l_y);
            pr = int'(paddle_r_y);
            if (m_dyd == 1) begin
                if (oy + 4 >= 472) begin ny = 472; m_dyd = 0; end
                else ny = oy + 4;
            end else begin
                if (oy < 4) begin ny = 0; m_dyd = 1; end
                else ny = oy - 4;
            end
            ovl = (oy + 8 > pl) && (oy < pl + 64);
            ovr = (oy + 8 > pr) && (oy < pr + 64);
            if (m_dxr == 1 && m_bx + 8 <= 616 && m_bx + 12 > 616 && ovr) begin
                m_bx = 608; m_dxr = 0;
            end else if (m_dxr == 0 && m_bx >= 24 && m_bx < 28 && ovl) begin
                m_bx = 24; m_dxr = 1;
            end else if (m_dxr == 1 && m_bx + 12 > 640) begin
                m_sl++; m_pl = 1; m_bx = 316; ny = 236; m_dxr = 1;
                if (m_sl == 9) m_state = 3; else begin m_state = 1; m_cnt = 32; end
            end else if (m_dxr == 0 && m_bx < 4) begin
                m_sr++; m_pr = 1; m_bx = 316; ny = 236; m_dxr = 0;
                if (m_sr == 9) m_state = 3; else begin m_state = 1; m_cnt = 32; end
            end else begin
                m_bx = (m_dxr == 1) ? m_bx + 4 : m_bx - 4;
            end
            m_by = ny;
        end
    endtask

    // Compare process: every clock, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ball_x",    int'(ball_x),    m_bx);
            chk("ball_y",    int'(ball_y),    m_by);
            chk("score_l",   int'(score_l),   m_sl);
            chk("score_r",   int'(score_r),   m_sr);
            chk("point_l",   int'(point_l),   m_pl);
            chk("point_r",   int'(point_r),   m_pr);
            chk("state",     int'(state),     m_state);
            chk("game_over", int'(game_over), (m_state == 3) ? 1 : 0);
        end
    end

    // Rising edge on game_tick; the tick takes effect at the 4th clock edge.
    task automatic do_tick(input int hold, input int lo, input bit st);
        @(negedge clk);
        if (st && (m_state == 1 || m_state == 2)) start = 1'b1;
        game_tick = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        model_tick();
        start = 1'b0;
        @(posedge clk);
        #1;
        m_pl = 0; m_pr = 0;
        repeat (hold) @(negedge clk);
        game_tick = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        model_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        #2;
        btnC = 1'b1;
        model_reset();
        #1;
        chk("rst_state",   int'(state),   0);
        chk("rst_ball_x",  int'(ball_x),  316);
        chk("rst_ball_y",  int'(ball_y),  236);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_score_r", int'(score_r), 0);
        chk("rst_points",  int'({point_l, point_r}), 0);
        @(negedge clk);
        @(negedge clk);
        btnC = 1'b0;
    endtask

    task automatic serve_phase();
        do_start();
        chk("serve_entry_state", int'(state), 1);
        for (int t = 1; t <= 32; t++) begin
            do_tick(0, 3, 1'b0);
            if (t == 31) begin
                chk("serve31_state",  int'(state),  1);
                chk("serve31_ball_x", int'(ball_x), 316);
            end
        end
        chk("serve_done_state", int'(state), 2);
    endtask

    initial begin
        int n;
        int v;
        btnC = 1'b1; game_tick = 1'b0; start = 1'b0;
        paddle_l_y = 10'd0; paddle_r_y = 10'd400;
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_state",  int'(state),  0);
        chk("init_ball_x", int'(ball_x), 316);
        chk("init_ball_y", int'(ball_y), 236);
        chk_en = 1'b1;
        btnC = 1'b0;
        repeat (3) @(negedge clk);

        // Rally: bottom wall then right paddle at y=400.
        serve_phase();
        // First play tick with an explicit latency probe; the level is then
        // held high for a long time and must not produce another tick.
        @(negedge clk);
        game_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("tick_not_yet", int'(ball_x), 316);
        @(posedge clk);
        #1;
        model_tick();
        chk("tick_at_3clk", int'(ball_x), 320);
        @(posedge clk);
        #1;
        repeat (20) @(negedge clk);
        chk("held_level_no_retick", int'(ball_x), 320);
        game_tick = 1'b0;
        repeat (4) @(negedge clk);
        for (int t = 2; t <= 75; t++) begin
            do_tick(0, 3, t[0]);
            if (t == 59) chk("p59_ball_y", int'(ball_y), 472);
            if (t == 60) chk("p60_ball_y", int'(ball_y), 468);
            if (t == 74) chk("p74_ball_x", int'(ball_x), 608);
            if (t == 75) chk("p75_ball_x", int'(ball_x), 604);
        end

        // Mid-play reset, then a right-side miss with the paddle at the top.
        do_reset_mid();
        repeat (3) @(negedge clk);
        paddle_r_y = 10'd0;
        serve_phase();
        for (int t = 1; t <= 80; t++) begin
            if (t == 80) begin
                @(negedge clk);
                game_tick = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                model_tick();
                chk("miss_point_l", int'(point_l), 1);
                chk("miss_score_l", int'(score_l), 1);
                chk("miss_ball_x",  int'(ball_x),  316);
                chk("miss_ball_y",  int'(ball_y),  236);
                chk("miss_state",   int'(state),   1);
                @(posedge clk);
                #1;
                m_pl = 0;
                chk("miss_point_l_drop", int'(point_l), 0);
                @(negedge clk);
                game_tick = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                do_tick(0, 3, 1'b0);
                if (t >= 74) chk("miss_pass_x", int'(ball_x), 612 + 4 * (t - 74));
            end
        end

        // Right paddle out of reach: left player runs to the winning score.
        paddle_r_y = 10'd1000;
        n = 0;
        while (m_state != 3 && n < 2000) begin
            do_tick(0, 3, 1'b0);
            n++;
        end
        chk("over_state",     int'(state),     3);
        chk("over_flag",      int'(game_over), 1);
        chk("over_score_l",   int'(score_l),   9);
        for (int t = 0; t < 5; t++) do_tick(0, 3, 1'b0);
        chk("over_ball_held", int'(ball_x), 316);
        do_start();
        chk("restart_score_l", int'(score_l), 0);
        chk("restart_state",   int'(state),   1);

        // Randomized play: tracking and random paddles, stray start pulses,
        // variable tick spacing and one asynchronous reset.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1500) begin
                do_reset_mid();
                repeat (3) @(negedge clk);
            end
            if ($urandom_range(0, 9) < 6) begin
                v = m_by - int'($urandom_range(0, 60));
                if (v < 0) v = 0;
                paddle_r_y = 10'(v);
            end else begin
                paddle_r_y = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 9) < 6) begin
                v = m_by - int'($urandom_range(0, 60));
                if (v < 0) v = 0;
                paddle_l_y = 10'(v);
            end else begin
                paddle_l_y = 10'($urandom_range(0, 479));
            end
            if ((m_state == 0 || m_state == 3) && $urandom_range(0, 3) == 0) do_start();
            else if ($urandom_range(0, 49) == 0) do_start();
            do_tick(int'($urandom_range(0, 4)), int'($urandom_range(3, 6)),
                    $urandom_range(0, 7) == 0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Consumes the slow game-rate clock level produced by the clock divider (btnC reset domain) and turns each rising edge into a one-cycle game tick.
- On each game tick, advances the ball position, bounces it off the top and bottom walls and both paddles, detects misses, and keeps score.
- Runs a serve/play/game-over state machine.
- Outputs drive the VGA renderer and the score display.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length in pixels (square ball)
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_XL, 16, left paddle left-edge x
- PADDLE_XR, 616, right paddle left-edge x
- STEP, 4, pixels moved per tick on each axis
- SERVE_DELAY, 32, ticks the ball is held at centre before play
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  system clock
- btnC  in  1  reset; asynchronous, active-high
- game_tick  in  1  slow clock level from the divider; asynchronous to internal logic
- start  in  1  start/restart request, level-sampled
- paddle_l_y  in  10  left paddle top y
- paddle_r_y  in  10  right paddle top y
- ball_x  out  10  ball top-left x
- ball_y  out  10  ball top-left y
- score_l  out  4  left player score
- score_r  out  4  right player score
- point_l  out  1  one-clk pulse: left player scored
- point_r  out  1  one-clk pulse: right player scored
- game_over  out  1  high in OVER state
- state  out  2  FSM state: IDLE=0, SERVE=1, PLAY=2, OVER=3

Behaviour:
Reset:
- Asynchronous on btnC high.
- state=IDLE, ball_x=316, ball_y=236 (centre = (SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2).
- dx=right, dy=down, scores=0, point pulses=0, serve counter=0, synchronizer and edge flops=0.
- Reset mid-game discards all state.

Tick generation:
- Two-flop synchronizer on game_tick, then a rising-edge detector.
- Produces tick, one clk wide, 3 clk after the game_tick rise.
- All motion happens only on tick cycles.

FSM:
- IDLE: ball held at centre. start=1 → SERVE, counter loaded with SERVE_DELAY.
- SERVE: ball held at centre. Each tick decrements the counter. On the tick where it reaches 0 → PLAY, so PLAY begins after exactly SERVE_DELAY ticks.
- PLAY: per tick, update Y then X, using the current (pre-update) ball_y for the paddle overlap test.
  - Y axis, moving down: if ball_y+STEP >= SCREEN_H-BALL_SIZE, clamp ball_y=SCREEN_H-BALL_SIZE and set dy=up; else ball_y+=STEP.
  - Y axis, moving up: if ball_y < STEP, clamp ball_y=0 and set dy=down; else ball_y-=STEP.
  - Overlap with paddle P: ball_y+BALL_SIZE > P AND ball_y < P+PADDLE_H.
  - Right hit: dx=right, ball_x+BALL_SIZE <= PADDLE_XR, ball_x+BALL_SIZE+STEP > PADDLE_XR, overlap(paddle_r_y) → ball_x=PADDLE_XR-BALL_SIZE, dx=left.
  - Left hit (mirror): dx=left, ball_x >= PADDLE_XL+PADDLE_W, ball_x < PADDLE_XL+PADDLE_W+STEP, overlap(paddle_l_y) → ball_x=PADDLE_XL+PADDLE_W, dx=right.
  - A ball already past a paddle edge is never re-hit.
  - Right miss: dx=right and ball_x+BALL_SIZE+STEP > SCREEN_W → score_l+1, point_l pulse, ball recentred, dx=right (serve toward the conceding player), dy unchanged.
  - Left miss: mirror of right miss; score_r+1, point_r pulse, dx=left.
  - After a point: if the new score == WIN_SCORE → OVER, else → SERVE with the counter reloaded.
  - Otherwise: ball_x ±= STEP.
- OVER: game_over=1, ball held at centre. start=1 → scores cleared, → SERVE.

Arithmetic and input rules:
- All coordinate arithmetic is 11-bit unsigned; no wrap.
- start is ignored in SERVE and PLAY.
- Scores never exceed WIN_SCORE.

Decomposition:
- Shared package pong_pkg:
  - state encoding constants
  - screen/paddle/ball geometry constants
  - coordinate width 10
- Sub-module tick_sync_edge: 2-flop synchronizer plus rising-edge pulse.
  - Ports: clk, btnC, async_in, pulse.
  - Reusable by the paddle controller.

Test Plan:
- Reset: pulse btnC mid-PLAY → state=0, ball=(316,236), scores=0, no point pulses.
- Tick timing: raise game_tick once → exactly one tick, 3 clk after the rise. Holding the level high gives no further ticks.
- Serve: start=1 in IDLE → state stays 1 for 32 ticks, then 2; ball_x remains 316 throughout SERVE.
- Bottom wall and right paddle hit: from serve, paddle_r_y=400.
  - Tick 59 of PLAY: ball_y=472, dy=up.
  - Tick 74: ball_x=608, dx=left.
  - Tick 75: ball_x=604.
- Right miss: paddle_r_y=0 → ball passes x=612..632 (ticks 74–79); tick 80: point_l=1 for 1 clk, score_l=1, ball=(316,236), state=1.
- Game over: force 9 left-player points → state=3, game_over=1, further ticks do not move the ball; start=1 → scores 0, state=1.
